// File: rtl/cp0_ctrl_if.sv
// Pipeline-to-CP0 signal bundle: mfc0/mtc0 port, M-stage exception info, interrupt lines.
interface cp0_ctrl_if;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic        cp0_we;
    logic [31:0] m_pc;
    logic        m_bd;
    logic [4:0]  m_exc_code;
    logic        m_eret;
    logic [5:0]  hw_int;
    logic [31:0] cp0_rdata;
    logic [31:0] epc_out;
    logic        req;

    modport master (
        output cp0_addr, cp0_wdata, cp0_we, m_pc, m_bd, m_exc_code, m_eret, hw_int,
        input  cp0_rdata, epc_out, req
    );

    modport slave (
        input  cp0_addr, cp0_wdata, cp0_we, m_pc, m_bd, m_exc_code, m_eret, hw_int,
        output cp0_rdata, epc_out, req
    );
endinterface

// File: rtl/cp0_ctrl.sv
// Coprocessor 0 for the five-stage core: SR/Cause/EPC/PRId, exception and interrupt
// request generation at M, and mfc0/mtc0 access.
module cp0_ctrl #(
    parameter logic [31:0] PRID_VALUE = 32'h2022_1106
) (
    input  logic         clk,
    input  logic         reset,
    cp0_ctrl_if.slave    bus
);
    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;
    localparam logic [4:0] ADDR_PRID  = 5'd15;

    logic [5:0]  sr_im;
    logic        sr_exl;
    logic        sr_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [29:0] epc_word;

    logic        int_req;
    logic        exc_req;
    logic        req;
    logic [31:0] sr_val;
    logic [31:0] cause_val;
    logic [31:0] epc_val;
    logic [31:0] rdata;
    logic        unused_pc_bits;

    // Interrupts look at the live lines; Cause.IP is only a software-visible snapshot.
    assign int_req = (|(bus.hw_int & sr_im)) & sr_ie & ~sr_exl;
    assign exc_req = (bus.m_exc_code != 5'd0) & ~sr_exl;
    assign req     = (int_req | exc_req) & ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cause_ip <= 6'd0;
        end else begin
            cause_ip <= bus.hw_int;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_im     <= 6'd0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_exc <= 5'd0;
            epc_word  <= 30'd0;
        end else if (req) begin
            sr_exl    <= 1'b1;
            cause_bd  <= bus.m_bd;
            cause_exc <= int_req ? 5'd0 : bus.m_exc_code;
            // Delay-slot victims restart at the branch, one word back.
            epc_word  <= bus.m_bd ? (bus.m_pc[31:2] - 30'd1) : bus.m_pc[31:2];
        end else begin
            if (bus.cp0_we && (bus.cp0_addr == ADDR_SR)) begin
                sr_im  <= bus.cp0_wdata[15:10];
                sr_exl <= bus.cp0_wdata[1];
                sr_ie  <= bus.cp0_wdata[0];
            end
            if (bus.cp0_we && (bus.cp0_addr == ADDR_EPC)) begin
                epc_word <= bus.cp0_wdata[31:2];
            end
            // Placed last so eret overrides a same-cycle mtc0 for EXL only.
            if (bus.m_eret) begin
                sr_exl <= 1'b0;
            end
        end
    end

    assign sr_val    = {16'h0, sr_im, 8'h0, sr_exl, sr_ie};
    assign cause_val = {cause_bd, 15'h0, cause_ip, 3'h0, cause_exc, 2'b00};
    assign epc_val   = {epc_word, 2'b00};

    always_comb begin
        rdata = 32'h0;
        case (bus.cp0_addr)
            ADDR_SR:    rdata = sr_val;
            ADDR_CAUSE: rdata = cause_val;
            ADDR_EPC:   rdata = epc_val;
            ADDR_PRID:  rdata = PRID_VALUE;
            default:    rdata = 32'h0;
        endcase
    end

    assign bus.cp0_rdata = rdata;
    assign bus.epc_out   = epc_val;
    assign bus.req       = req;

    assign unused_pc_bits = &{1'b0, bus.m_pc[1:0]};
endmodule

// File: tb/tb_cp0_ctrl.sv
// Directed and randomized checks of cp0_ctrl against a word-level reference model.
module tb_cp0_ctrl;
    localparam logic [31:0] PRID = 32'h2022_1106;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    logic [31:0] m_sr;
    logic [31:0] m_cause;
    logic [31:0] m_epc;

    cp0_ctrl_if bus ();

    cp0_ctrl #(.PRID_VALUE(PRID)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic model_int();
        return (|(bus.hw_int & m_sr[15:10])) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic logic model_req();
        if (reset) return 1'b0;
        return model_int() || ((bus.m_exc_code != 5'd0) && !m_sr[1]);
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return PRID;
            default: return 32'h0;
        endcase
    endfunction

    task automatic idle();
        bus.cp0_addr   = 5'd0;
        bus.cp0_wdata  = 32'h0;
        bus.cp0_we     = 1'b0;
        bus.m_pc       = 32'h0;
        bus.m_bd       = 1'b0;
        bus.m_exc_code = 5'd0;
        bus.m_eret     = 1'b0;
        bus.hw_int     = 6'd0;
    endtask

    // Advance one clock and apply the architectural update rules to the model.
    task automatic tick();
        logic        take;
        logic        intr;
        logic [31:0] pc_al;
        @(posedge clk);
        if (reset) begin
            m_sr = 0; m_cause = 0; m_epc = 0;
        end else begin
            take  = model_req();
            intr  = model_int();
            pc_al = bus.m_pc & 32'hFFFF_FFFC;
            if (take) begin
                m_sr[1]      = 1'b1;
                m_cause[31]  = bus.m_bd;
                m_cause[6:2] = intr ? 5'd0 : bus.m_exc_code;
                m_epc        = bus.m_bd ? pc_al - 32'd4 : pc_al;
            end else begin
                if (bus.cp0_we && bus.cp0_addr == 5'd12) m_sr = bus.cp0_wdata & 32'h0000_FC03;
                if (bus.cp0_we && bus.cp0_addr == 5'd14) m_epc = bus.cp0_wdata & 32'hFFFF_FFFC;
                if (bus.m_eret) m_sr[1] = 1'b0;
            end
            m_cause[15:10] = bus.hw_int;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        bus.m_exc_code = 5'd7;
        #1;
        checks++;
        if (bus.req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", bus.req); end
        checks++;
        if (bus.epc_out !== 32'h0) begin errors++; $display("FAIL reset_epc_out: got %h want 0", bus.epc_out); end
        for (int a = 12; a <= 14; a++) begin
            bus.cp0_addr = a[4:0];
            #1;
            checks++;
            if (bus.cp0_rdata !== 32'h0) begin
                errors++; $display("FAIL reset_read%0d: got %h want 0", a, bus.cp0_rdata);
            end
        end
        tick();
        tick();
        reset = 1'b0;
        idle();
    endtask

    task automatic test_interrupt();
        idle();
        bus.cp0_we = 1'b1; bus.cp0_addr = 5'd12; bus.cp0_wdata = 32'h0000_FC01;
        #1;
        checks++;
        if (bus.req !== 1'b0) begin errors++; $display("FAIL int_mtc0_req: got %b want 0", bus.req); end
        tick();
        idle();
        bus.hw_int = 6'b000100; bus.m_pc = 32'h0000_2000;
        #1;
        checks++;
        if (bus.req !== 1'b1) begin errors++; $display("FAIL int_req: got %b want 1", bus.req); end
        tick();
        idle();
        bus.cp0_addr = 5'd13;
        #1;
        checks++;
        if (bus.cp0_rdata !== 32'h0000_1000) begin errors++; $display("FAIL int_cause: got %h want 00001000", bus.cp0_rdata); end
        bus.cp0_addr = 5'd12;
        #1;
        checks++;
        if (bus.cp0_rdata !== 32'h0000_FC03) begin errors++; $display("FAIL int_sr: got %h want 0000fc03", bus.cp0_rdata); end
        checks++;
        if (bus.epc_out !== 32'h0000_2000) begin errors++; $display("FAIL int_epc: got %h want 00002000", bus.epc_out); end
        bus.m_eret = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_exc_bd();
        bus.m_exc_code = 5'd4; bus.m_bd = 1'b1; bus.m_pc = 32'h0000_3010;
        #1;
        checks++;
        if (bus.req !== 1'b1) begin errors++; $display("FAIL exc_req: got %b want 1", bus.req); end
        tick();
        idle();
        bus.cp0_addr = 5'd13;
        #1;
        checks++;
        if (bus.epc_out !== 32'h0000_300C) begin errors++; $display("FAIL exc_bd_epc: got %h want 0000300c", bus.epc_out); end
        checks++;
        if (bus.cp0_rdata !== 32'h8000_0010) begin errors++; $display("FAIL exc_bd_cause: got %h want 80000010", bus.cp0_rdata); end
    endtask

    task automatic test_exl_mask();
        bus.m_exc_code = 5'd10; bus.m_pc = 32'h7777_0000;
        #1;
        checks++;
        if (bus.req !== 1'b0) begin errors++; $display("FAIL exl_mask_req: got %b want 0", bus.req); end
        tick();
        idle();
        bus.cp0_addr = 5'd13;
        #1;
        checks++;
        if (bus.epc_out !== 32'h0000_300C) begin errors++; $display("FAIL exl_mask_epc: got %h want 0000300c", bus.epc_out); end
        checks++;
        if (bus.cp0_rdata !== 32'h8000_0010) begin errors++; $display("FAIL exl_mask_cause: got %h want 80000010", bus.cp0_rdata); end
        bus.m_eret = 1'b1;
        tick();
        idle();
        bus.cp0_addr = 5'd12;
        #1;
        checks++;
        if (bus.cp0_rdata !== 32'h0000_FC01) begin errors++; $display("FAIL eret_sr: got %h want 0000fc01", bus.cp0_rdata); end
    endtask

    task automatic test_mtc0_drop();
        bus.cp0_we = 1'b1; bus.cp0_addr = 5'd14; bus.cp0_wdata = 32'h1234_5678;
        bus.m_exc_code = 5'd12; bus.m_pc = 32'h0000_5008;
        #1;
        checks++;
        if (bus.cp0_rdata !== 32'h0000_300C) begin errors++; $display("FAIL same_cycle_read: got %h want 0000300c", bus.cp0_rdata); end
        tick();
        idle();
        #1;
        checks++;
        if (bus.epc_out !== 32'h0000_5008) begin errors++; $display("FAIL drop_epc: got %h want 00005008", bus.epc_out); end
        // eret and mtc0 SR together while in the handler: eret owns EXL
        bus.cp0_we = 1'b1; bus.cp0_addr = 5'd12; bus.cp0_wdata = 32'h0000_0003; bus.m_eret = 1'b1;
        tick();
        idle();
        bus.cp0_addr = 5'd12;
        #1;
        checks++;
        if (bus.cp0_rdata !== 32'h0000_0001) begin errors++; $display("FAIL eret_vs_mtc0: got %h want 00000001", bus.cp0_rdata); end
        bus.cp0_we = 1'b1; bus.cp0_addr = 5'd14; bus.cp0_wdata = 32'h1234_5678;
        tick();
        idle();
        bus.cp0_addr = 5'd14;
        #1;
        checks++;
        if (bus.cp0_rdata !== 32'h1234_5678) begin errors++; $display("FAIL mtc0_epc: got %h want 12345678", bus.cp0_rdata); end
    endtask

    task automatic test_priority();
        bus.cp0_we = 1'b1; bus.cp0_addr = 5'd12; bus.cp0_wdata = 32'h0000_FC01;
        tick();
        idle();
        bus.hw_int = 6'b000001; bus.m_exc_code = 5'd4; bus.m_pc = 32'h0000_6000;
        #1;
        checks++;
        if (bus.req !== 1'b1) begin errors++; $display("FAIL prio_req: got %b want 1", bus.req); end
        tick();
        idle();
        bus.cp0_addr = 5'd13;
        #1;
        checks++;
        if (bus.cp0_rdata !== 32'h0000_0400) begin errors++; $display("FAIL prio_cause: got %h want 00000400", bus.cp0_rdata); end
        bus.cp0_addr = 5'd15;
        #1;
        checks++;
        if (bus.cp0_rdata !== PRID) begin errors++; $display("FAIL prid: got %h want %h", bus.cp0_rdata, PRID); end
        bus.cp0_addr = 5'd3;
        #1;
        checks++;
        if (bus.cp0_rdata !== 32'h0) begin errors++; $display("FAIL unmapped_read: got %h want 0", bus.cp0_rdata); end
        bus.m_eret = 1'b1; bus.hw_int = 6'b000001;
        tick();
        bus.m_eret = 1'b0;
    endtask

    task automatic test_async_reset();
        bus.cp0_addr = 5'd13;
        #1;
        checks++;
        if (bus.req !== 1'b1 || bus.cp0_rdata !== 32'h0000_0400) begin
            errors++; $display("FAIL pre_reset: got req=%b cause=%h want req=1 cause=00000400", bus.req, bus.cp0_rdata);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus.req !== 1'b0) begin errors++; $display("FAIL async_req: got %b want 0", bus.req); end
        checks++;
        if (bus.epc_out !== 32'h0) begin errors++; $display("FAIL async_epc: got %h want 0", bus.epc_out); end
        checks++;
        if (bus.cp0_rdata !== 32'h0) begin errors++; $display("FAIL async_cause: got %h want 0", bus.cp0_rdata); end
        tick();
        bus.cp0_addr = 5'd12;
        #1;
        checks++;
        if (bus.cp0_rdata !== 32'h0) begin errors++; $display("FAIL async_sr: got %h want 0", bus.cp0_rdata); end
        tick();
        reset = 1'b0;
        idle();
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 7);
            bus.cp0_addr   = (r < 4) ? 5'(12 + r) : (r == 4) ? 5'd3 : 5'($urandom_range(0, 31));
            bus.cp0_we     = ($urandom_range(0, 3) == 0);
            bus.cp0_wdata  = $urandom;
            bus.m_pc       = $urandom;
            bus.m_bd       = $urandom_range(0, 1) == 1;
            bus.m_exc_code = ($urandom_range(0, 9) < 7) ? 5'd0 : 5'($urandom_range(1, 31));
            bus.m_eret     = ($urandom_range(0, 6) == 0);
            bus.hw_int     = ($urandom_range(0, 9) < 7) ? 6'd0 : 6'($urandom_range(1, 63));
            #1;
            checks++;
            if (bus.req !== model_req()) begin
                errors++; $display("FAIL rand_req[%0d]: got %b want %b", i, bus.req, model_req());
            end
            checks++;
            if (bus.cp0_rdata !== model_read(bus.cp0_addr)) begin
                errors++; $display("FAIL rand_rdata[%0d] addr %0d: got %h want %h", i, bus.cp0_addr, bus.cp0_rdata, model_read(bus.cp0_addr));
            end
            checks++;
            if (bus.epc_out !== m_epc) begin
                errors++; $display("FAIL rand_epc[%0d]: got %h want %h", i, bus.epc_out, m_epc);
            end
            tick();
        end
        idle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_sr = 0; m_cause = 0; m_epc = 0;
        reset = 1'b1;
        idle();
        @(negedge clk);
        test_reset();
        test_interrupt();
        test_exc_bd();
        test_exl_mask();
        test_mtc0_drop();
        test_priority();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
